// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: NOP encoding, fetch FSM
// states and the IF/ID register layout.
package fetch_stage_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ISSUE must stay at encoding zero so a power-up-cleared state register is safe.
  typedef enum logic [2:0] {
    S_ISSUE = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{instruction: NOP, pc: '0, pc_plus4: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetch response that arrives while decode
// is stalled. Reads back NOP when empty.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [31:0] data_q;
  logic        full_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      data_q <= NOP;
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = full_q ? data_q : NOP;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps at most one word read outstanding and
// loads the IF/ID register, handling stall, redirect, drain and fault.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d, reset_state;
  logic [31:0]  pc_q, pc_d, pc_inc, addr;
  ifid_t        ifid_q, ifid_d;
  logic         fault_q, fault_d;
  logic         req, outstanding;
  logic         skid_load, skid_unload, skid_clear;
  logic [31:0]  skid_data;

  assign pc_inc      = pc_q + 32'd4;
  assign outstanding = (state_q == S_WAIT) || (state_q == S_DRAIN);
  // A reset that lands on an in-flight read must still swallow its response.
  assign reset_state = (outstanding && !imem_rvalid) ? S_DRAIN : S_ISSUE;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    fault_d     = fault_q;
    req         = 1'b0;
    addr        = pc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    if (state_q == S_FAULT) begin
      fault_d = 1'b1;
    end else if (redirect) begin
      ifid_d.valid       = 1'b0;
      ifid_d.instruction = NOP;
      skid_clear         = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end else begin
        pc_d    = redirect_pc;
        state_d = (outstanding && !imem_rvalid) ? S_DRAIN : S_ISSUE;
      end
    end else begin
      case (state_q)
        S_ISSUE: begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end else begin
              ifid_d = '{instruction: imem_rdata, pc: pc_q, pc_plus4: pc_inc, valid: 1'b1};
              req    = 1'b1;
              addr   = pc_inc;
              pc_d   = pc_inc;
            end
          end else if (!stall) begin
            ifid_d.valid       = 1'b0;
            ifid_d.instruction = NOP;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_d      = '{instruction: skid_data, pc: pc_q, pc_plus4: pc_inc, valid: 1'b1};
            skid_unload = 1'b1;
            req         = 1'b1;
            addr        = pc_inc;
            pc_d        = pc_inc;
            state_d     = S_WAIT;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_ISSUE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= reset_state;
      pc_q    <= RESET_PC;
      ifid_q  <= IFID_RESET;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      fault_q <= fault_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk_i    (clock),
    .rst_i    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .data_i   (imem_rdata),
    .data_o   (skid_data)
  );

  assign imem_req       = req && !reset;
  assign imem_addr      = {addr[31:2], 2'b00};
  assign if_instruction = ifid_q.instruction;
  assign if_pc          = ifid_q.pc;
  assign if_pc_plus4    = ifid_q.pc_plus4;
  assign if_valid       = ifid_q.valid;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1- or 2-cycle instruction memory that
// returns address-tagged words.
module tb_fetch_stage;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset, stall, redirect, imem_rvalid, imem_req;
  logic        if_valid, fetch_fault;
  logic [31:0] redirect_pc, imem_rdata, imem_addr;
  logic [31:0] if_instruction, if_pc, if_pc_plus4;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          lat = 1;
  bit          pv [1:2];
  logic [31:0] pa [1:2];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_valid       (if_valid),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
    if (v) begin
      chk({tag, "_instr"}, if_instruction, word_of(pc));
      chk({tag, "_pc"}, if_pc, pc);
      chk({tag, "_pc4"}, if_pc_plus4, pc + 32'd4);
    end else begin
      chk({tag, "_nop"}, if_instruction, NOP_W);
    end
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) chk({tag, "_addr"}, imem_addr, a);
  endtask

  // Records this cycle's request, advances one clock, presents the memory
  // response and the new control inputs, then lets outputs settle.
  task automatic tick(input logic rst_v, input logic st_v, input logic rd_v,
                      input logic [31:0] rpc);
    @(negedge clock);
    if (imem_req) begin
      pv[lat] = 1'b1;
      pa[lat] = imem_addr;
    end
    @(posedge clock);
    #1;
    imem_rvalid = pv[1];
    imem_rdata  = pv[1] ? word_of(pa[1]) : 32'hDEAD_BEEF;
    pv[1] = pv[2];
    pa[1] = pa[2];
    pv[2] = 1'b0;
    reset       = rst_v;
    stall       = st_v;
    redirect    = rd_v;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    pv[1] = 1'b0; pv[2] = 1'b0; pa[1] = '0; pa[2] = '0;

    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instruction, NOP_W);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc_plus4, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // Streaming with 1-cycle memory
    tick(0, 0, 0, 0); chk_req("c0", 1, 32'h0); chk_if("c0", 0, 0);
    tick(0, 0, 0, 0); chk_req("c1", 1, 32'h4); chk_if("c1", 0, 0);
    for (int k = 2; k <= 5; k++) begin
      tick(0, 0, 0, 0);
      chk_if("stream", 1, 32'(4 * (k - 2)));
      chk_req("stream", 1, 32'(4 * k));
    end

    // Three stall cycles with a response landing in the first
    tick(0, 1, 0, 0); chk_if("st6", 1, 32'h10); chk_req("st6", 0, 0);
    tick(0, 1, 0, 0); chk_if("st7", 1, 32'h10); chk_req("st7", 0, 0);
    tick(0, 1, 0, 0); chk_if("st8", 1, 32'h10); chk_req("st8", 0, 0);
    tick(0, 0, 0, 0); chk_if("st9", 1, 32'h10); chk_req("st9", 1, 32'h18);
    tick(0, 0, 0, 0); chk_if("st10", 1, 32'h14); chk_req("st10", 1, 32'h1C);
    tick(0, 0, 0, 0); chk_if("st11", 1, 32'h18); chk_req("st11", 1, 32'h20);
    lat = 2;

    // Redirect to 0x100 with a 2-cycle read outstanding
    tick(0, 0, 1, 32'h100); chk_if("rd12", 1, 32'h1C); chk_req("rd12", 0, 0);
    tick(0, 0, 0, 0); chk_if("rd13", 0, 0); chk_req("rd13", 0, 0);
    tick(0, 0, 0, 0); chk_if("rd14", 0, 0); chk_req("rd14", 1, 32'h100);
    tick(0, 0, 0, 0); chk_if("rd15", 0, 0); chk_req("rd15", 0, 0);
    tick(0, 0, 0, 0); chk_if("rd16", 0, 0); chk_req("rd16", 1, 32'h104);
    tick(0, 0, 0, 0); chk_if("rd17", 1, 32'h100); chk_req("rd17", 0, 0);
    tick(0, 0, 0, 0); chk_if("rd18", 0, 0); chk_req("rd18", 1, 32'h108);

    // Redirect together with stall
    tick(0, 1, 1, 32'h200); chk_if("rs19", 1, 32'h104); chk_req("rs19", 0, 0);
    tick(0, 0, 0, 0); chk_if("rs20", 0, 0); chk_req("rs20", 0, 0);
    lat = 1;
    tick(0, 0, 0, 0); chk_if("rs21", 0, 0); chk_req("rs21", 1, 32'h200);
    tick(0, 0, 0, 0); chk_if("rs22", 0, 0); chk_req("rs22", 1, 32'h204);

    // PC wrap at the top of the address space
    tick(0, 0, 1, 32'hFFFF_FFF8); chk_if("w23", 1, 32'h200); chk_req("w23", 0, 0);
    tick(0, 0, 0, 0); chk_if("w24", 0, 0); chk_req("w24", 1, 32'hFFFF_FFF8);
    tick(0, 0, 0, 0); chk_if("w25", 0, 0); chk_req("w25", 1, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0); chk_if("w26", 1, 32'hFFFF_FFF8); chk_req("w26", 1, 32'h0);
    tick(0, 0, 0, 0); chk_if("w27", 1, 32'hFFFF_FFFC); chk_req("w27", 1, 32'h4);
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    tick(0, 0, 0, 0); chk_if("w28", 1, 32'h0); chk_req("w28", 1, 32'h8);
    lat = 2;

    // Reset with a read outstanding: its late response must be dropped
    tick(1, 0, 0, 0); chk_if("mr29", 1, 32'h4); chk_req("mr29", 0, 0);
    tick(0, 0, 0, 0); chk_if("mr30", 0, 0); chk_req("mr30", 0, 0);
    chk("mr30_pc", if_pc, 32'h0);
    tick(0, 0, 0, 0); chk_if("mr31", 0, 0); chk_req("mr31", 1, 32'h0);
    tick(0, 0, 0, 0); chk_if("mr32", 0, 0); chk_req("mr32", 0, 0);
    tick(0, 0, 0, 0); chk_if("mr33", 0, 0); chk_req("mr33", 1, 32'h4);
    tick(0, 0, 0, 0); chk_if("mr34", 1, 32'h0); chk_req("mr34", 0, 0);
    lat = 1;
    tick(0, 0, 0, 0); chk_if("mr35", 0, 0); chk_req("mr35", 1, 32'h8);

    // Misaligned redirect: sticky fault until reset
    tick(0, 0, 1, 32'h102); chk_if("f36", 1, 32'h4); chk_req("f36", 0, 0);
    chk("f36_fault", {31'd0, fetch_fault}, 32'd0);
    tick(0, 0, 0, 0); chk_if("f37", 0, 0); chk_req("f37", 0, 0);
    chk("f37_fault", {31'd0, fetch_fault}, 32'd1);
    tick(0, 0, 1, 32'h300); chk_if("f38", 0, 0); chk_req("f38", 0, 0);
    chk("f38_fault", {31'd0, fetch_fault}, 32'd1);
    tick(0, 0, 0, 0); chk_if("f39", 0, 0); chk_req("f39", 0, 0);
    chk("f39_fault", {31'd0, fetch_fault}, 32'd1);
    tick(1, 0, 0, 0); chk_req("f40", 0, 0);
    tick(0, 0, 0, 0); chk_if("f41", 0, 0); chk_req("f41", 1, 32'h0);
    chk("f41_fault", {31'd0, fetch_fault}, 32'd0);
    tick(0, 0, 0, 0); chk_if("f42", 0, 0); chk_req("f42", 1, 32'h4);
    tick(0, 0, 0, 0); chk_if("f43", 1, 32'h0); chk_req("f43", 1, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
